// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and the 11-bit host-to-device frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAITIDLE
    } state_e;

    localparam logic [7:0] CMD_LEDS  = 8'hED;
    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] CMD_ECHO  = 8'hEE;
    localparam logic [7:0] ACK_BYTE  = 8'hFA;

    localparam int FRAME_W = 11;

    // {stop, odd parity, data LSB-first, start}; bit 0 goes on the wire first.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins, plus a falling-edge
// detector on the synchronised clock that only looks at the line on ce ticks.
module ps2_sync (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic ck_i,
    input  logic dq_i,
    output logic ck_o,
    output logic dq_o,
    output logic ck_fall_o
);

    logic [1:0] ck_sync_q;
    logic [1:0] dq_sync_q;
    logic       ck_prev_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            ck_sync_q <= 2'b11;
            dq_sync_q <= 2'b11;
            ck_prev_q <= 1'b1;
        end else begin
            ck_sync_q <= {ck_sync_q[0], ck_i};
            dq_sync_q <= {dq_sync_q[0], dq_i};
            if (ce) begin
                ck_prev_q <= ck_sync_q[1];
            end
        end
    end

    assign ck_o      = ck_sync_q[1];
    assign dq_o      = dq_sync_q[1];
    assign ck_fall_o = ce & ck_prev_q & ~ck_sync_q[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, clocks out one command
// byte on device-generated clocks, checks the device ack, and times out.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT = 852,
    parameter int TIMEOUT = 106500,
    parameter int TW      = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2CkI,
    input  logic       ps2DqI,
    output logic       ps2CkOe,
    output logic       ps2DqOe,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Tick k after acceptance sees tick_q == k-1: clock held for INHIBIT ticks,
    // start bit asserted on the last of them.
    localparam logic [TW-1:0] DQ_TICK  = TW'(INHIBIT - 1);
    localparam logic [TW-1:0] REL_TICK = TW'(INHIBIT);
    localparam logic [TW-1:0] TO_TICK  = TW'(TIMEOUT - 1);

    logic ck_s, dq_s, ck_fall;

    ps2_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .ck_i     (ps2CkI),
        .dq_i     (ps2DqI),
        .ck_o     (ck_s),
        .dq_o     (dq_s),
        .ck_fall_o(ck_fall)
    );

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [3:0]           idx_q, idx_d;
    logic                 ck_oe_q, ck_oe_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            frame_q <= '0;
            idx_q   <= '0;
            ck_oe_q <= 1'b0;
            dq_oe_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            ck_oe_q <= ck_oe_d;
            dq_oe_q <= dq_oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        ck_oe_d = ck_oe_q;
        dq_oe_d = dq_oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        if (state_q != S_IDLE && ce) begin
            tick_d = tick_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INHIBIT;
                    busy_d  = 1'b1;
                    tick_d  = '0;
                    frame_d = make_frame(data);
                end
            end
            S_INHIBIT: begin
                if (ce) begin
                    if (tick_q == '0) begin
                        ck_oe_d = 1'b1;
                    end
                    if (tick_q == DQ_TICK) begin
                        dq_oe_d = ~frame_q[0];
                    end
                    if (tick_q == REL_TICK) begin
                        ck_oe_d = 1'b0;
                        idx_d   = 4'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (ck_fall) begin
                    dq_oe_d = ~frame_q[idx_q];
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd10) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (ck_fall) begin
                    if (!dq_s) begin
                        state_d = S_WAITIDLE;
                    end else begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAITIDLE: begin
                if (ce && ck_s && dq_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides anything decided above on the same tick.
        if (state_q != S_IDLE && ce && tick_q == TO_TICK) begin
            state_d = S_IDLE;
            ck_oe_d = 1'b0;
            dq_oe_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b1;
        end
    end

    assign ps2CkOe = ck_oe_q;
    assign ps2DqOe = dq_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a behavioural keyboard on the open-drain pair
// records what it samples, and every frame is compared with the expected bits.
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int INHIBIT    = 852;
    localparam int TB_TIMEOUT = 3000;
    localparam int TW         = 17;
    localparam int HALF       = 30;   // device half clock period in system clocks

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce    = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       dev_ck = 1'b1;
    logic       dev_dq = 1'b1;
    logic       ps2CkOe, ps2DqOe, busy, done, error;
    logic       ck_line, dq_line;

    assign ck_line = ps2CkOe ? 1'b0 : dev_ck;
    assign dq_line = ps2DqOe ? 1'b0 : dev_dq;

    ps2_tx #(.INHIBIT(INHIBIT), .TIMEOUT(TB_TIMEOUT), .TW(TW)) dut (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .ps2CkI (ck_line),
        .ps2DqI (dq_line),
        .ps2CkOe(ps2CkOe),
        .ps2DqOe(ps2DqOe),
        .start  (start),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock); #1 ce = 1'b1;
            @(posedge clock); #1 ce = 1'b0;
        end
    end

    int checks   = 0;
    int failures = 0;

    // Passive monitor: pulse counts, inhibit tick counts and protocol sanity.
    int   cyc, done_cnt, err_cnt, both_pulse_cnt, inh_ticks, both_oe_ticks;
    int   busy_glitch, oe_glitch, err_cyc;
    logic prev_ck_oe = 1'b0, prev_dq_oe = 1'b0, prev_busy = 1'b0;
    logic prev_ce = 1'b0, prev_rst = 1'b1;

    always @(negedge clock) begin
        cyc++;
        if (done) done_cnt++;
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (done && error) both_pulse_cnt++;
        if (ce && ps2CkOe) inh_ticks++;
        if (ce && ps2CkOe && ps2DqOe) both_oe_ticks++;
        if (prev_busy && !busy && !done && !error && !prev_rst) busy_glitch++;
        if (((ps2CkOe !== prev_ck_oe) || (ps2DqOe !== prev_dq_oe)) && !prev_ce && !prev_rst)
            oe_glitch++;
        prev_ck_oe = ps2CkOe;
        prev_dq_oe = ps2DqOe;
        prev_busy  = busy;
        prev_ce    = ce;
        prev_rst   = reset;
    end

    // Bits the device should see: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic pulse_start(input logic [7:0] d);
        @(posedge clock); #1 start = 1'b1; data = d;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2000) begin @(negedge clock); t++; end
    endtask

    // Keyboard model: waits for request-to-send, then produces n_clk clocks,
    // sampling DQ on each rising edge and optionally acking on the 11th clock.
    task automatic dev_frame(input int n_clk, input bit give_ack,
                             output logic [10:0] smp, output bit rts_ok, output int fall11_cyc);
        int t = 0;
        smp = '1; rts_ok = 1'b0; fall11_cyc = 0;
        while (!(ps2CkOe === 1'b0 && ps2DqOe === 1'b1) && t < 4 * INHIBIT + 200) begin
            @(negedge clock); t++;
        end
        if (ps2CkOe === 1'b0 && ps2DqOe === 1'b1) begin
            rts_ok = 1'b1;
            smp[0] = dq_line;
            repeat (HALF) @(negedge clock);
            for (int k = 1; k <= n_clk; k++) begin
                dev_ck = 1'b0;
                if (k == 11) fall11_cyc = cyc;
                repeat (HALF) @(negedge clock);
                dev_ck = 1'b1;
                if (k <= 10) smp[k] = dq_line;
                if (k == 10 && give_ack) dev_dq = 1'b0;
                if (k == 11) dev_dq = 1'b1;
                repeat (HALF) @(negedge clock);
            end
        end
        dev_dq = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input bit ack,
                        output logic [10:0] smp, output bit ok, output int f11);
        pulse_start(d);
        dev_frame(11, ack, smp, ok, f11);
        wait_idle();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({ps2CkOe, ps2DqOe, busy, done, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold: got %b expected 00000", {ps2CkOe, ps2DqOe, busy, done, error});
        end
        @(posedge clock); #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if ({ps2CkOe, ps2DqOe, busy, done, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b expected 00000", {ps2CkOe, ps2DqOe, busy, done, error});
        end
    endtask

    task automatic test_leds();
        logic [10:0] smp; bit ok; int f11;
        int inh0 = inh_ticks, both0 = both_oe_ticks, d0 = done_cnt, e0 = err_cnt;
        send(CMD_LEDS, 1'b1, smp, ok, f11);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL leds_rts: got %0d expected 1", ok); end
        checks++;
        if (inh_ticks - inh0 != INHIBIT) begin
            failures++; $display("FAIL leds_inhibit_ticks: got %0d expected %0d", inh_ticks - inh0, INHIBIT);
        end
        checks++;
        if (both_oe_ticks - both0 != 1) begin
            failures++; $display("FAIL leds_start_bit_ticks: got %0d expected 1", both_oe_ticks - both0);
        end
        checks++;
        if (smp !== exp_frame(CMD_LEDS)) begin
            failures++; $display("FAIL leds_frame: got %b expected %b", smp, exp_frame(CMD_LEDS));
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            failures++; $display("FAIL leds_done: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({busy, ps2CkOe, ps2DqOe} !== 3'b000) begin
            failures++; $display("FAIL leds_idle: got %b expected 000", {busy, ps2CkOe, ps2DqOe});
        end
    endtask

    task automatic test_parity();
        logic [7:0] pats [2];
        pats[0] = 8'h00;
        pats[1] = 8'h01;
        for (int p = 0; p < 2; p++) begin
            logic [10:0] smp; bit ok; int f11;
            logic [10:0] exp;
            int d0 = done_cnt;
            exp = exp_frame(pats[p]);
            send(pats[p], 1'b1, smp, ok, f11);
            checks++;
            if (smp[9] !== exp[9] || smp !== exp) begin
                failures++; $display("FAIL parity_%02h: got %b expected %b", pats[p], smp, exp);
            end
            checks++;
            if (done_cnt - d0 != 1 || busy !== 1'b0) begin
                failures++; $display("FAIL parity_done_%02h: got %0d busy=%b expected 1 busy=0", pats[p], done_cnt - d0, busy);
            end
        end
    endtask

    task automatic test_timeout();
        int ticks = 0, t = 0;
        int d0 = done_cnt, e0 = err_cnt;
        pulse_start(CMD_RESET);
        while (t < 4 * TB_TIMEOUT) begin
            @(negedge clock);
            if (error) break;
            if (ce) ticks++;
            t++;
        end
        checks++;
        if (ticks != TB_TIMEOUT || error !== 1'b1) begin
            failures++; $display("FAIL timeout_ticks: got %0d error=%b expected %0d error=1", ticks, error, TB_TIMEOUT);
        end
        checks++;
        if ({ps2CkOe, ps2DqOe, busy} !== 3'b000) begin
            failures++; $display("FAIL timeout_release: got %b expected 000", {ps2CkOe, ps2DqOe, busy});
        end
        repeat (4) @(negedge clock);
        checks++;
        if (done_cnt != d0 || err_cnt - e0 != 1) begin
            failures++; $display("FAIL timeout_pulses: got done=%0d err=%0d expected 0 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_nack();
        logic [10:0] smp; bit ok; int f11;
        logic [7:0] d = 8'($urandom);
        int d0 = done_cnt, e0 = err_cnt;
        send(d, 1'b0, smp, ok, f11);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || busy !== 1'b0) begin
            failures++; $display("FAIL nack_error: got err=%0d done=%0d busy=%b expected 1 0 0", err_cnt - e0, done_cnt - d0, busy);
        end
        checks++;
        if (err_cyc - f11 < 1 || err_cyc - f11 > 8) begin
            failures++; $display("FAIL nack_latency: got %0d cycles expected 1..8", err_cyc - f11);
        end
    endtask

    task automatic test_busy_ignore();
        logic [10:0] smp; bit ok; int f11;
        int d0 = done_cnt, g0 = busy_glitch;
        pulse_start(CMD_LEDS);
        fork
            dev_frame(11, 1'b1, smp, ok, f11);
            begin
                repeat (2 * INHIBIT + 200) @(negedge clock);
                pulse_start(8'h55);
                @(negedge clock);
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy_high: got %b expected 1", busy); end
            end
        join
        wait_idle();
        checks++;
        if (smp !== exp_frame(CMD_LEDS)) begin
            failures++; $display("FAIL ignore_frame: got %b expected %b", smp, exp_frame(CMD_LEDS));
        end
        checks++;
        if (done_cnt - d0 != 1 || busy_glitch != g0) begin
            failures++; $display("FAIL ignore_done: got done=%0d glitches=%0d expected 1 0", done_cnt - d0, busy_glitch - g0);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] smp, smp2; bit ok, ok2; int f11;
        int d0 = done_cnt;
        @(posedge clock); #1 start = 1'b1; data = CMD_LEDS;
        @(posedge clock); #1 data = CMD_ECHO;
        fork
            dev_frame(11, 1'b1, smp, ok, f11);
            begin
                int t = 0;
                @(negedge clock);
                while (!done && t < 6000) begin @(negedge clock); t++; end
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    failures++; $display("FAIL b2b_done_edge: got done=%b busy=%b expected 1 0", done, busy);
                end
                @(posedge clock); #1 start = 1'b0;
                @(negedge clock);
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL b2b_next_accept: got %b expected 1", busy); end
            end
        join
        start = 1'b0;
        dev_frame(11, 1'b1, smp2, ok2, f11);
        wait_idle();
        checks++;
        if (smp !== exp_frame(CMD_LEDS) || smp2 !== exp_frame(CMD_ECHO)) begin
            failures++; $display("FAIL b2b_frames: got %b %b expected %b %b", smp, smp2, exp_frame(CMD_LEDS), exp_frame(CMD_ECHO));
        end
        checks++;
        if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] smp, exp; bit ok; int f11;
        int d0 = done_cnt, e0 = err_cnt;
        exp = exp_frame(CMD_LEDS);
        pulse_start(CMD_LEDS);
        dev_frame(5, 1'b0, smp, ok, f11);
        checks++;
        if (busy !== 1'b1 || ps2DqOe !== ~exp[5]) begin
            failures++; $display("FAIL midreset_bit4: got busy=%b dqoe=%b expected 1 %b", busy, ps2DqOe, ~exp[5]);
        end
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        checks++;
        if ({ps2CkOe, ps2DqOe, busy, done, error} !== 5'b0) begin
            failures++; $display("FAIL midreset_release: got %b expected 00000", {ps2CkOe, ps2DqOe, busy, done, error});
        end
        repeat (10) @(negedge clock);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            failures++; $display("FAIL midreset_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
        end
        send(CMD_RESET, 1'b1, smp, ok, f11);
        checks++;
        if (smp !== exp_frame(CMD_RESET) || done_cnt - d0 != 1) begin
            failures++; $display("FAIL midreset_fresh: got %b done=%0d expected %b done=1", smp, done_cnt - d0, exp_frame(CMD_RESET));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [10:0] smp; bit ok; int f11;
            logic [7:0] d = 8'($urandom);
            bit ack = ($urandom_range(0, 3) != 0);
            int d0 = done_cnt, e0 = err_cnt;
            send(d, ack, smp, ok, f11);
            checks++;
            if (smp !== exp_frame(d)) begin
                failures++; $display("FAIL rand_frame_%02h: got %b expected %b", d, smp, exp_frame(d));
            end
            checks++;
            if (done_cnt - d0 != int'(ack) || err_cnt - e0 != int'(!ack) || busy !== 1'b0) begin
                failures++; $display("FAIL rand_result_%02h: got done=%0d err=%0d busy=%b expected %0d %0d 0",
                                     d, done_cnt - d0, err_cnt - e0, busy, int'(ack), int'(!ack));
            end
        end
    endtask

    initial begin
        test_reset();
        test_leds();
        test_parity();
        test_timeout();
        test_nack();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (both_pulse_cnt != 0 || busy_glitch != 0 || oe_glitch != 0) begin
            failures++;
            $display("FAIL protocol_sanity: got both=%0d busy_glitch=%0d oe_glitch=%0d expected 0 0 0",
                     both_pulse_cnt, busy_glitch, oe_glitch);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
